// File: rtl/px_color_stats_pkg.sv
// px_pkg: colour codes, RGB332 field positions and FSM state encoding
// shared by px_color_stats and px_classify.
package px_pkg;

    typedef enum logic [1:0] {
        COLOR_NONE  = 2'd0,
        COLOR_RED   = 2'd1,
        COLOR_GREEN = 2'd2,
        COLOR_BLUE  = 2'd3
    } color_e;

    // RGB332 layout: R=[7:5], G=[4:2], B=[1:0]
    localparam int R_HI = 7;
    localparam int R_LO = 5;
    localparam int G_HI = 4;
    localparam int G_LO = 2;
    localparam int B_HI = 1;
    localparam int B_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_REPORT  = 2'd3
    } state_e;

endpackage

// File: rtl/px_color_stats_classify.sv
// px_classify: combinational RGB332 byte -> dominant-colour class.
// A channel wins only if it beats both others by at least THRESH
// (3-bit scale); with THRESH=0 ties fall to R, then G, then B.
module px_classify
    import px_pkg::*;
#(
    parameter int THRESH = 1
) (
    input  logic [7:0] px_data,
    output color_e     px_class
);

    // Margins above 7 can never be met; clamp so the 5-bit sums cannot wrap.
    localparam logic [4:0] TH = (THRESH > 8) ? 5'd8 : 5'(THRESH);

    logic [4:0] r5, g5, b5;
    logic       dom_r, dom_g, dom_b;

    assign r5 = {2'b00, px_data[R_HI:R_LO]};
    assign g5 = {2'b00, px_data[G_HI:G_LO]};
    // Stretch the 2-bit blue field to 3 bits by repeating its MSB.
    assign b5 = {2'b00, px_data[B_HI:B_LO], px_data[B_HI]};

    assign dom_r = (r5 >= g5 + TH) && (r5 >= b5 + TH);
    assign dom_g = (g5 >= r5 + TH) && (g5 >= b5 + TH);
    assign dom_b = (b5 >= r5 + TH) && (b5 >= g5 + TH);

    // Priority-ordered class select.
    always_comb begin
        px_class = COLOR_NONE;
        if (dom_r)
            px_class = COLOR_RED;
        else if (dom_g)
            px_class = COLOR_GREEN;
        else if (dom_b)
            px_class = COLOR_BLUE;
    end

endmodule

// File: rtl/px_color_stats.sv
// px_color_stats: per-frame dominant-colour statistics tapped from the
// capture write stream. Counts sampled pixels per class between VSYNC
// falling and rising edges, then reports the winner over valid/ready.
// Optional build macro PX_COLOR_STATS_ROI_EN restricts counting to the
// address window [ROI_LO, ROI_HI].
module px_color_stats
    import px_pkg::*;
#(
    parameter int AW        = 17,
    parameter int CW        = 17,
    parameter int THRESH    = 1,
    parameter int MIN_COUNT = 64
`ifdef PX_COLOR_STATS_ROI_EN
    ,
    parameter int ROI_LO    = 25600,
    parameter int ROI_HI    = 51199
`endif
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          vsync,
    input  logic          px_wr,
    input  logic [AW-1:0] mem_px_addr,
    input  logic [7:0]    mem_px_data,
    input  logic          result_ready,
    output logic          result_valid,
    output logic [1:0]    result_color,
    output logic [CW-1:0] cnt_red,
    output logic [CW-1:0] cnt_green,
    output logic [CW-1:0] cnt_blue,
    output logic [CW-1:0] cnt_total,
    output logic          overrun
);

    localparam logic [CW:0] MIN_C = (CW+1)'(MIN_COUNT);

    // Counter increment that sticks at all-ones.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    state_e        state, state_nxt;
    logic          vsync_p1, px_wr_p1;
    logic          vs_fall, vs_rise, sample, roi_ok;
    color_e        px_class;
    logic [CW-1:0] acc_r, acc_g, acc_b, acc_t;
    logic [CW-1:0] max_cnt;
    color_e        top_class, win_q;

    px_classify #(
        .THRESH (THRESH)
    ) u_classify (
        .px_data  (mem_px_data),
        .px_class (px_class)
    );

`ifdef PX_COLOR_STATS_ROI_EN
    assign roi_ok = (mem_px_addr >= AW'(ROI_LO)) && (mem_px_addr <= AW'(ROI_HI));
`else
    // Address only matters for ROI filtering; reduce it so the port stays loaded.
    assign roi_ok = 1'b1 | (^mem_px_addr);
`endif

    assign vs_fall = vsync_p1 & ~vsync;
    assign vs_rise = ~vsync_p1 & vsync;
    assign sample  = px_wr & ~px_wr_p1 & roi_ok;

    // Edge-detect registers for VSYNC and the write strobe.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            vsync_p1 <= 1'b0;
            px_wr_p1 <= 1'b0;
        end else begin
            vsync_p1 <= vsync;
            px_wr_p1 <= px_wr;
        end
    end

    // FSM state register.
    always_ff @(posedge pclk) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state; a VSYNC rise outside ACCUM is a missed frame and ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (vs_fall) state_nxt = ST_ACCUM;
            ST_ACCUM:   if (vs_rise) state_nxt = ST_RESOLVE;
            ST_RESOLVE: state_nxt = ST_REPORT;
            ST_REPORT:  state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Working counters: zero outside a frame, saturating increments in ACCUM.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
            acc_t <= '0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (sample) begin
                        acc_t <= sat_inc(acc_t);
                        case (px_class)
                            COLOR_RED:   acc_r <= sat_inc(acc_r);
                            COLOR_GREEN: acc_g <= sat_inc(acc_g);
                            COLOR_BLUE:  acc_b <= sat_inc(acc_b);
                            default:     ;
                        endcase
                    end
                end
                ST_RESOLVE: ;
                default: begin
                    acc_r <= '0;
                    acc_g <= '0;
                    acc_b <= '0;
                    acc_t <= '0;
                end
            endcase
        end
    end

    // Largest class count, ties resolved R > G > B.
    always_comb begin
        top_class = COLOR_BLUE;
        max_cnt   = acc_b;
        if (acc_r >= acc_g && acc_r >= acc_b) begin
            top_class = COLOR_RED;
            max_cnt   = acc_r;
        end else if (acc_g >= acc_b) begin
            top_class = COLOR_GREEN;
            max_cnt   = acc_g;
        end
    end

    // Winner register, loaded in RESOLVE with the MIN_COUNT gate applied.
    always_ff @(posedge pclk) begin
        if (!rst)
            win_q <= COLOR_NONE;
        else if (state == ST_RESOLVE)
            win_q <= ({1'b0, max_cnt} >= MIN_C) ? top_class : COLOR_NONE;
    end

    // Result outputs and handshake; REPORT always overwrites, flagging unaccepted results.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            result_valid <= 1'b0;
            result_color <= 2'd0;
            cnt_red      <= '0;
            cnt_green    <= '0;
            cnt_blue     <= '0;
            cnt_total    <= '0;
            overrun      <= 1'b0;
        end else if (state == ST_REPORT) begin
            result_valid <= 1'b1;
            result_color <= win_q;
            cnt_red      <= acc_r;
            cnt_green    <= acc_g;
            cnt_blue     <= acc_b;
            cnt_total    <= acc_t;
            if (result_valid && !result_ready)
                overrun <= 1'b1;
        end else if (result_valid && result_ready) begin
            result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_px_color_stats.sv
// Self-checking bench for px_color_stats: directed frames from the test
// plan with literal expectations, then randomized frames, all checked
// every cycle against a frame-level behavioural model.
module tb_px_color_stats;

    localparam int AW        = 17;
    localparam int CW        = 17;
    localparam int THRESH    = 1;
    localparam int MIN_COUNT = 64;
    localparam int SAT       = (1 << CW) - 1;
    localparam int ROI_LO    = 25600;
    localparam int ROI_HI    = 51199;

    logic          pclk = 1'b0;
    logic          rst = 1'b0;
    logic          vsync = 1'b1;
    logic          px_wr = 1'b0;
    logic [AW-1:0] mem_px_addr = 17'd30000;
    logic [7:0]    mem_px_data = 8'h00;
    logic          result_ready = 1'b0;
    logic          result_valid;
    logic [1:0]    result_color;
    logic [CW-1:0] cnt_red, cnt_green, cnt_blue, cnt_total;
    logic          overrun;

    int tests = 0;
    int fails = 0;
    bit rand_rdy = 0;

    px_color_stats dut (
        .pclk         (pclk),
        .rst          (rst),
        .vsync        (vsync),
        .px_wr        (px_wr),
        .mem_px_addr  (mem_px_addr),
        .mem_px_data  (mem_px_data),
        .result_ready (result_ready),
        .result_valid (result_valid),
        .result_color (result_color),
        .cnt_red      (cnt_red),
        .cnt_green    (cnt_green),
        .cnt_blue     (cnt_blue),
        .cnt_total    (cnt_total),
        .overrun      (overrun)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Class of one RGB332 byte: the channel that beats both others by THRESH.
    function automatic int model_class(input logic [7:0] d);
        int ch [3];
        ch[0] = int'(d[7:5]);
        ch[1] = int'(d[4:2]);
        ch[2] = int'(d[1:0]) * 2 + int'(d[1]);
        for (int x = 0; x < 3; x++) begin
            bit ok = 1;
            for (int o = 0; o < 3; o++)
                if (o != x && ch[x] < ch[o] + THRESH) ok = 0;
            if (ok) return x + 1;
        end
        return 0;
    endfunction

    function automatic bit model_roi(input logic [AW-1:0] a);
`ifdef PX_COLOR_STATS_ROI_EN
        return (int'(a) >= ROI_LO) && (int'(a) <= ROI_HI);
`else
        return (a == a);
`endif
    endfunction

    bit m_live = 0;
    bit m_in, m_vs_q, m_wr_q;
    int m_cnt [4];           // index 0 = total, 1..3 = R,G,B
    int pend_delay;
    int p_cnt [4];
    int p_color;
    bit e_valid, e_ov;
    int e_color;
    int e_cnt [4];

    task automatic model_step();
        bit smp;
        if (!rst) begin
            m_live = 1; m_in = 0; m_vs_q = 0; m_wr_q = 0;
            pend_delay = 0; e_valid = 0; e_ov = 0; e_color = 0;
            for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; e_cnt[i] = 0; end
            return;
        end
        smp = px_wr && !m_wr_q && model_roi(mem_px_addr);
        // Result becomes visible two edges after the VSYNC rise is seen.
        if (pend_delay == 1) begin
            if (e_valid && !result_ready) e_ov = 1;
            e_valid = 1;
            e_color = p_color;
            for (int i = 0; i < 4; i++) e_cnt[i] = p_cnt[i];
        end else if (e_valid && result_ready) begin
            e_valid = 0;
        end
        if (pend_delay > 0) pend_delay--;
        if (m_in && smp) begin
            int c = model_class(mem_px_data);
            if (m_cnt[0] < SAT) m_cnt[0]++;
            if (c != 0 && m_cnt[c] < SAT) m_cnt[c]++;
        end
        if (m_in && vsync && !m_vs_q) begin
            int best = 1;
            for (int i = 2; i <= 3; i++) if (m_cnt[i] > m_cnt[best]) best = i;
            p_color = (m_cnt[best] >= MIN_COUNT) ? best : 0;
            for (int i = 0; i < 4; i++) begin p_cnt[i] = m_cnt[i]; m_cnt[i] = 0; end
            pend_delay = 2;
            m_in = 0;
        end else if (!m_in && pend_delay == 0 && !vsync && m_vs_q) begin
            m_in = 1;
        end
        m_vs_q = vsync;
        m_wr_q = px_wr;
    endtask

    initial forever begin
        @(posedge pclk);
        model_step();
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge pclk);
        if (m_live) begin
            chk("m_valid",   int'(result_valid), int'(e_valid));
            chk("m_color",   int'(result_color), e_color);
            chk("m_red",     int'(cnt_red),      e_cnt[1]);
            chk("m_green",   int'(cnt_green),    e_cnt[2]);
            chk("m_blue",    int'(cnt_blue),     e_cnt[3]);
            chk("m_total",   int'(cnt_total),    e_cnt[0]);
            chk("m_overrun", int'(overrun),      int'(e_ov));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            if (rand_rdy) result_ready = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic pulse(input logic [7:0] d, input logic [AW-1:0] a);
        @(negedge pclk);
        px_wr = 1'b1; mem_px_data = d; mem_px_addr = a;
        if (rand_rdy) result_ready = ($urandom_range(0, 3) == 0);
        @(negedge pclk);
        px_wr = 1'b0;
        if (rand_rdy) result_ready = ($urandom_range(0, 3) == 0);
    endtask

    task automatic frame_start();
        @(negedge pclk); vsync = 1'b0;
        tick(2);
    endtask

    task automatic accept();
        @(negedge pclk); result_ready = 1'b1;
        @(negedge pclk); result_ready = 1'b0;
    endtask

    function automatic logic [7:0] rand_px();
        case ($urandom_range(0, 4))
            0: return 8'hE0;
            1: return 8'h1C;
            2: return 8'h03;
            3: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b0; vsync = 1'b1;
        repeat (3) @(negedge pclk);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_color", int'(result_color), 0);
        chk("rst_total", int'(cnt_total), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst = 1'b1;
        tick(3);

        // 200 red pixels, latency check
        frame_start();
        repeat (200) pulse(8'hE0, 17'd30000);
        @(negedge pclk); vsync = 1'b1;
        @(negedge pclk); chk("lat_e0", int'(result_valid), 0);
        @(negedge pclk); chk("lat_e1", int'(result_valid), 0);
        @(negedge pclk); chk("lat_e2", int'(result_valid), 1);
        chk("red_color", int'(result_color), 1);
        chk("red_cnt", int'(cnt_red), 200);
        chk("red_total", int'(cnt_total), 200);
        accept();
        chk("red_accepted", int'(result_valid), 0);
        tick(3);

        // 100 green + 40 blue, held unaccepted for 10 cycles
        frame_start();
        for (int i = 0; i < 140; i++) pulse((i < 100) ? 8'h1C : 8'h03, 17'd30000);
        @(negedge pclk); vsync = 1'b1;
        repeat (3) @(negedge pclk);
        for (int i = 0; i < 10; i++) begin
            chk("gb_valid", int'(result_valid), 1);
            chk("gb_color", int'(result_color), 2);
            chk("gb_green", int'(cnt_green), 100);
            chk("gb_blue", int'(cnt_blue), 40);
            @(negedge pclk);
        end
        accept();
        chk("gb_accepted", int'(result_valid), 0);
        tick(3);

        // 30 red: below MIN_COUNT
        frame_start();
        repeat (30) pulse(8'hE0, 17'd30000);
        @(negedge pclk); vsync = 1'b1;
        repeat (3) @(negedge pclk);
        chk("few_valid", int'(result_valid), 1);
        chk("few_color", int'(result_color), 0);
        chk("few_red", int'(cnt_red), 30);
        accept();
        tick(3);

        // Two frames without acceptance -> overrun
        frame_start();
        repeat (70) pulse(8'h1C, 17'd30000);
        @(negedge pclk); vsync = 1'b1;
        tick(5);
        chk("ov_first_valid", int'(result_valid), 1);
        chk("ov_first_flag", int'(overrun), 0);
        frame_start();
        repeat (80) pulse(8'h03, 17'd30000);
        @(negedge pclk); vsync = 1'b1;
        repeat (3) @(negedge pclk);
        chk("ov_valid", int'(result_valid), 1);
        chk("ov_color", int'(result_color), 3);
        chk("ov_blue", int'(cnt_blue), 80);
        chk("ov_green", int'(cnt_green), 0);
        chk("ov_flag", int'(overrun), 1);
        accept();
        tick(3);
        chk("ov_sticky", int'(overrun), 1);

        // Held strobe counts once, grey is unclassified
        frame_start();
        @(negedge pclk); px_wr = 1'b1; mem_px_data = 8'hFF; mem_px_addr = 17'd30000;
        repeat (5) @(negedge pclk);
        px_wr = 1'b0;
        pulse(8'hFF, 17'd30000);
        @(negedge pclk); vsync = 1'b1;
        repeat (3) @(negedge pclk);
        chk("hold_total", int'(cnt_total), 2);
        chk("hold_red", int'(cnt_red), 0);
        chk("hold_green", int'(cnt_green), 0);
        chk("hold_blue", int'(cnt_blue), 0);
        accept();
        tick(3);

        // Reset mid-frame, then a rise in IDLE produces nothing
        frame_start();
        repeat (20) pulse(8'hE0, 17'd30000);
        @(negedge pclk); rst = 1'b0;
        repeat (2) @(negedge pclk);
        rst = 1'b1;
        tick(2);
        @(negedge pclk); vsync = 1'b1;
        tick(5);
        chk("midrst_valid", int'(result_valid), 0);
        chk("midrst_overrun", int'(overrun), 0);

`ifdef PX_COLOR_STATS_ROI_EN
        // ROI filter: only the in-window half counts
        frame_start();
        repeat (10) pulse(8'hE0, 17'd100);
        repeat (10) pulse(8'hE0, 17'd30000);
        @(negedge pclk); vsync = 1'b1;
        repeat (3) @(negedge pclk);
        chk("roi_red", int'(cnt_red), 10);
        chk("roi_total", int'(cnt_total), 10);
        accept();
        tick(3);
`endif

        // Randomized frames with random consumer readiness
        rand_rdy = 1;
        for (int f = 0; f < 10; f++) begin
            int n = $urandom_range(0, 150);
            frame_start();
            for (int i = 0; i < n; i++) begin
                pulse(rand_px(), 17'($urandom));
                if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
            end
            @(negedge pclk);
            vsync = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                // Sample in the same cycle as the VSYNC rise
                px_wr = 1'b1; mem_px_data = rand_px(); mem_px_addr = 17'($urandom);
                @(negedge pclk); px_wr = 1'b0;
            end
            tick($urandom_range(5, 12));
        end
        rand_rdy = 0;
        @(negedge pclk); result_ready = 1'b1;
        tick(3);
        result_ready = 1'b0;
        tick(2);
        chk("drain_valid", int'(result_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
